div_radix2: RTL and testbench
=============================

DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL provide port: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL provide port: resetn  in  1  reset, synchronous, active-low; one clock; takes effect on the rising edge of clk.
REQ-003 SHALL provide port: div_startE  in  1  E-stage DIV/DIVU request; held high while the instruction sits in E.
REQ-004 SHALL provide port: signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL provide port: a  in  32  dividend (rs value after forwarding).
REQ-006 SHALL provide port: b  in  32  divisor (rt value after forwarding).
REQ-007 SHALL provide port: flush  in  1  cancel the operation; driven by is_exceptM.
REQ-008 SHALL provide port: ext_stall  in  1  pipeline stall from non-divider sources (i_stall | d_stall).
REQ-009 SHALL provide port: div_stallE  out  1  combinational stall request to the hazard unit.
REQ-010 SHALL provide port: result  out  64  [63:32] = remainder (HI), [31:0] = quotient (LO).
REQ-011 SHALL provide port: ready  out  1  result valid.

Function
REQ-012 SHALL implement three states: IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-013 In IDLE, with div_startE=1 and flush=0, SHALL latch |a|, |b|, sign(a) and sign(a)^sign(b), clear the counter and enter BUSY (acceptance cycle = cycle 0).
REQ-014 Absolute values SHALL be taken only when signed_div=1; for DIVU the operands are used raw.
REQ-015 In BUSY, SHALL perform one restoring step per cycle: shift {rem,quot} left by 1, then trial-subtract the divisor from the upper 33 bits; if the result is non-negative, keep the difference and set quotient LSB=1.
REQ-016 BUSY SHALL last exactly 32 cycles (counter 0..31) and then enter DONE; the first DONE cycle is cycle 33.
REQ-017 On entering DONE, if signed_div=1, SHALL negate the quotient when the quotient sign is 1 and negate the remainder when sign(a)=1; results are truncated mod 2^32.
REQ-018 div_stallE SHALL equal ~flush & ((state==IDLE & div_startE) | state==BUSY), i.e. high for cycles 0..32 and low in DONE.
REQ-019 In DONE, ready SHALL be 1 and result SHALL be held stable.
REQ-020 In DONE, SHALL stay in DONE while ext_stall=1 and go to IDLE when ext_stall=0; it SHALL never restart on the still-high div_startE.
REQ-021 In IDLE and BUSY, ready SHALL be 0; result keeps its last value.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, clear ready and abandon the partial result; flush has priority over start.
REQ-023 Divide by zero (b==0) SHALL take full latency and yield quotient=0xFFFFFFFF and remainder=a, for both DIV and DIVU, with no sign fix-up.
REQ-024 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient=0x80000000 and remainder=0.
REQ-025 Operand changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-026 When resetn=0 at a clk edge, SHALL set state=IDLE, counter=0, ready=0, result=0 and all operand/sign registers to 0.
REQ-027 While resetn=0, div_stallE SHALL be 0.
REQ-028 Reset asserted mid-BUSY SHALL abort the operation with no residual effect on the next division.

Verification
REQ-029 DIVU a=100, b=7 -> div_stallE high cycles 0..32; cycle 33: ready=1, result={32'd2, 32'd14}.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-031 DIVU a=5, b=0 -> after 33 cycles, result={32'd5, 32'hFFFFFFFF}.
REQ-032 flush pulsed when counter=10 -> next cycle: state IDLE, ready=0, div_stallE=0; a following DIVU 9/3 gives quotient=3, remainder=0 with full latency.
REQ-033 ext_stall=1 for 3 cycles in DONE with div_startE held high -> ready=1 and result stable all 3 cycles, no restart; ext_stall=0 -> IDLE next cycle, div_stallE=0.
REQ-034 resetn=0 at counter=20 -> ready=0, result=0, div_stallE=0; next DIVU 100/7 is correct.

Source files
------------

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for the E stage: 32 quotient bits, one per cycle,
// with signed fix-up, divide-by-zero and flush/stall handshaking to the hazard unit.
module div_radix2 #(
  localparam int unsigned DataW = 32,
  localparam int unsigned CntW  = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 div_startE,
  input  logic                 signed_div,
  input  logic [DataW-1:0]     a,
  input  logic [DataW-1:0]     b,
  input  logic                 flush,
  input  logic                 ext_stall,
  output logic                 div_stallE,
  output logic [2*DataW-1:0]   result,
  output logic                 ready
);

  localparam logic [CntW-1:0] LastCnt = CntW'(DataW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  function automatic logic [DataW-1:0] negate(input logic [DataW-1:0] x);
    return ~x + DataW'(1);
  endfunction

  divState_t          state,      stateNext;
  logic [CntW-1:0]    cnt,        cntNext;
  logic [DataW-1:0]   remReg,     remNext;
  logic [DataW-1:0]   quotReg,    quotNext;
  logic [DataW-1:0]   divisorReg, divisorNext;
  logic               negQuot,    negQuotNext;
  logic               negRem,     negRemNext;
  logic [2*DataW-1:0] resultNext;
  logic               readyNext;

  // Operand conditioning at acceptance
  logic             aNeg;
  logic             bNeg;
  logic             bZero;
  logic [DataW-1:0] dividendIn;
  logic [DataW-1:0] divisorIn;

  always_comb begin
    aNeg       = signed_div & a[DataW-1];
    bNeg       = signed_div & b[DataW-1];
    bZero      = (b == '0);
    // With a zero divisor the dividend passes through raw so the remainder equals a.
    dividendIn = (aNeg && !bZero) ? negate(a) : a;
    divisorIn  = bNeg ? negate(b) : b;
  end

  // One restoring step: shift {rem,quot} left, trial-subtract divisor from upper 33 bits
  logic [DataW:0]   partial;
  logic [DataW:0]   trial;
  logic             geq;
  logic [DataW-1:0] stepRem;
  logic [DataW-1:0] stepQuot;
  logic [DataW-1:0] finalQuot;
  logic [DataW-1:0] finalRem;

  always_comb begin
    partial  = {remReg, quotReg[DataW-1]};
    trial    = partial - {1'b0, divisorReg};
    // rem < divisor keeps a successful difference below 2^32, so bit 32 is the borrow.
    geq      = ~trial[DataW];
    stepRem  = geq ? trial[DataW-1:0] : partial[DataW-1:0];
    stepQuot = {quotReg[DataW-2:0], geq};
    finalQuot = negQuot ? negate(stepQuot) : stepQuot;
    finalRem  = negRem  ? negate(stepRem)  : stepRem;
  end

  // Next-state and datapath updates
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    remNext     = remReg;
    quotNext    = quotReg;
    divisorNext = divisorReg;
    negQuotNext = negQuot;
    negRemNext  = negRem;
    resultNext  = result;
    readyNext   = 1'b0;

    if (flush) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_startE) begin
            stateNext   = BUSY;
            cntNext     = '0;
            remNext     = '0;
            quotNext    = dividendIn;
            divisorNext = divisorIn;
            negQuotNext = (aNeg ^ bNeg) & ~bZero;
            negRemNext  = aNeg & ~bZero;
          end
        end
        BUSY: begin
          remNext  = stepRem;
          quotNext = stepQuot;
          cntNext  = cnt + CntW'(1);
          if (cnt == LastCnt) begin
            stateNext  = DONE;
            readyNext  = 1'b1;
            resultNext = {finalRem, finalQuot};
          end
        end
        DONE: begin
          // Hold the result until the pipeline advances; never re-accept the same start.
          if (ext_stall) begin
            readyNext = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      remReg     <= '0;
      quotReg    <= '0;
      divisorReg <= '0;
      negQuot    <= 1'b0;
      negRem     <= 1'b0;
      result     <= '0;
      ready      <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      remReg     <= remNext;
      quotReg    <= quotNext;
      divisorReg <= divisorNext;
      negQuot    <= negQuotNext;
      negRem     <= negRemNext;
      result     <= resultNext;
      ready      <= readyNext;
    end
  end

  // Stall request: covers the acceptance cycle and all BUSY cycles, dropped by flush/reset
  always_comb begin
    div_stallE = resetn & ~flush &
                 (((state == IDLE) & div_startE) | (state == BUSY));
  end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed/unsigned results, divide by zero,
// flush, ext_stall hold in DONE and mid-operation reset.
module tb_div_radix2;

  logic        clk;
  logic        resetn;
  logic        div_startE;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ext_stall;
  logic        div_stallE;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  div_radix2 dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_startE (div_startE),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .ext_stall  (ext_stall),
    .div_stallE (div_stallE),
    .result     (result),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current (IDLE) cycle: this is cycle 0.
  task automatic startOp(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    div_startE = 1'b1;
    signed_div = sgn;
    a          = x;
    b          = y;
    #1;
  endtask

  // Advance until ready (bounded); n = cycles after cycle 0.
  task automatic waitDone(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 100);
  endtask

  // Leave DONE: pipeline advances, start drops.
  task automatic finishOp();
    div_startE = 1'b0;
    ext_stall  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    div_startE = 1'b1;
    #1;
    checks++;
    if (div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", div_stallE);
    end
    tick();
    tick();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b result=%h expected ready=0 result=0", ready, result);
    end
    resetn     = 1'b1;
    div_startE = 1'b0;
    tick();
  endtask

  task automatic test_divu_basic();
    int bad = 0;
    startOp(1'b0, 32'd100, 32'd7);
    if (div_stallE !== 1'b1) bad++;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      tick();
      if (cyc == 1) begin
        a = 32'hDEAD_BEEF;
        b = 32'd3;
      end
      #1;
      if (div_stallE !== 1'b1 || ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL divu_busy_window: %0d bad cycles in 0..32, expected 0", bad);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || result !== {32'd2, 32'd14} || div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL divu_100_7: ready=%b stall=%b result=%h expected ready=1 stall=0 result=%h",
               ready, div_stallE, result, {32'd2, 32'd14});
    end
    finishOp();
    checks++;
    if (ready !== 1'b0 || div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL divu_idle: ready=%b stall=%b expected 0 0", ready, div_stallE);
    end
  endtask

  task automatic test_signed();
    logic        sg[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] xa[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] xb[5] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [63:0] ex[5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                           {32'h0000_0000, 32'h8000_0000},
                           {32'h0000_0001, 32'hFFFF_FFFD},
                           {32'hFFFF_FFFF, 32'h0000_0003},
                           {32'h8000_0000, 32'h0000_0000}};
    int n;
    for (int i = 0; i < 5; i++) begin
      startOp(sg[i], xa[i], xb[i]);
      waitDone(n);
      checks++;
      if (n !== 33 || result !== ex[i]) begin
        errors++;
        $display("FAIL signed_vec%0d: latency=%0d result=%h expected latency=33 result=%h",
                 i, n, result, ex[i]);
      end
      finishOp();
    end
  endtask

  task automatic test_div_by_zero();
    logic        sg[2] = '{1'b0, 1'b1};
    logic [31:0] xa[2] = '{32'd5, 32'hFFFF_FFF9};
    logic [63:0] ex[2] = '{{32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
    int n;
    for (int i = 0; i < 2; i++) begin
      startOp(sg[i], xa[i], 32'd0);
      waitDone(n);
      checks++;
      if (n !== 33 || result !== ex[i]) begin
        errors++;
        $display("FAIL divzero_vec%0d: latency=%0d result=%h expected latency=33 result=%h",
                 i, n, result, ex[i]);
      end
      finishOp();
    end
  endtask

  task automatic test_flush();
    int n;
    startOp(1'b0, 32'd1000, 32'd3);
    for (int cyc = 1; cyc <= 11; cyc++) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b expected 0", div_stallE);
    end
    tick();
    flush      = 1'b0;
    div_startE = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%b stall=%b expected 0 0", ready, div_stallE);
    end
    // flush beats a start presented in IDLE
    div_startE = 1'b1;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    div_startE = 1'b0;
    #1;
    checks++;
    if (div_stallE !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority: stall=%b ready=%b expected 0 0", div_stallE, ready);
    end
    startOp(1'b0, 32'd9, 32'd3);
    waitDone(n);
    checks++;
    if (n !== 33 || result !== {32'd0, 32'd3}) begin
      errors++;
      $display("FAIL flush_next_9_3: latency=%0d result=%h expected latency=33 result=%h",
               n, result, {32'd0, 32'd3});
    end
    finishOp();
  endtask

  task automatic test_ext_stall();
    int n;
    startOp(1'b0, 32'd100, 32'd7);
    waitDone(n);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ready !== 1'b1 || result !== {32'd2, 32'd14} || div_stallE !== 1'b0) begin
        errors++;
        $display("FAIL ext_stall_hold%0d: ready=%b stall=%b result=%h expected 1 0 %h",
                 i, ready, div_stallE, result, {32'd2, 32'd14});
      end
      if (i == 2) ext_stall = 1'b0;
      tick();
    end
    div_startE = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL ext_stall_release: ready=%b stall=%b expected 0 0", ready, div_stallE);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    startOp(1'b0, 32'd55, 32'd5);
    for (int cyc = 1; cyc <= 21; cyc++) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: got %b expected 0", div_stallE);
    end
    tick();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b result=%h expected 0 0", ready, result);
    end
    resetn     = 1'b1;
    div_startE = 1'b0;
    tick();
    startOp(1'b0, 32'd100, 32'd7);
    waitDone(n);
    checks++;
    if (n !== 33 || result !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL reset_mid_next: latency=%0d result=%h expected latency=33 result=%h",
               n, result, {32'd2, 32'd14});
    end
    finishOp();
  endtask

  task automatic test_back_to_back();
    int n;
    startOp(1'b0, 32'hFFFF_FFFF, 32'h10);
    waitDone(n);
    checks++;
    if (n !== 33 || result !== {32'hF, 32'h0FFF_FFFF}) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d result=%h expected latency=33 result=%h",
               n, result, {32'hF, 32'h0FFF_FFFF});
    end
    finishOp();
    startOp(1'b1, 32'hFFFF_FF9C, 32'd10);
    checks++;
    if (result !== {32'hF, 32'h0FFF_FFFF} || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_hold: ready=%b result=%h expected ready=0 result=%h",
               ready, result, {32'hF, 32'h0FFF_FFFF});
    end
    waitDone(n);
    checks++;
    if (n !== 33 || result !== {32'h0, 32'hFFFF_FFF6}) begin
      errors++;
      $display("FAIL b2b_second: latency=%0d result=%h expected latency=33 result=%h",
               n, result, {32'h0, 32'hFFFF_FFF6});
    end
    finishOp();
  endtask

  initial begin
    resetn     = 1'b0;
    div_startE = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    flush      = 1'b0;
    ext_stall  = 1'b0;
    tick();
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_flush();
    test_ext_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
